// File: rtl/mem_ctrl.sv
// mem_ctrl: single-master request/response front end for a bank of
// synchronous SRAM chips that share address, data and control lines.
// The upper request address bits select one chip; the controller runs
// a fixed accept / access / respond sequence and returns read data.
// Every mem_* output is a flop (or a tristate gated by a flop), so the
// chip bus never sees a combinational path from the request inputs.

module mem_ctrl_checker #(
  parameter int NUM_CHIPS = 3
) (
  input logic                 clk,
  input logic                 rst,
  input logic [NUM_CHIPS-1:0] mem_cs,
  input logic                 mem_we,
  input logic                 mem_oe,
  input logic                 drive,
  input logic                 rsp_valid,
  input logic                 req_ready
);

  // Only one chip may be selected at a time.
  a_cs_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(mem_cs));

  // Write and output enable are never both active on the shared bus.
  a_we_oe_excl : assert property (@(posedge clk) disable iff (rst) !(mem_we && mem_oe));

  // The controller drives the data bus only during a write access.
  a_drive_we   : assert property (@(posedge clk) disable iff (rst) (!drive || mem_we));

  // A response cycle never accepts a new request.
  a_rsp_busy   : assert property (@(posedge clk) disable iff (rst) !(rsp_valid && req_ready));

endmodule

module mem_ctrl #(
  parameter int CHIP_ADDR_WIDTH = 12,
  parameter int DATA_WIDTH      = 8,
  parameter int NUM_CHIPS       = 3,
  parameter int SEL_WIDTH       = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic                                 req_we,
  input  logic [CHIP_ADDR_WIDTH+SEL_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]                req_wdata,
  output logic                                 rsp_valid,
  output logic [DATA_WIDTH-1:0]                rsp_rdata,
  output logic                                 rsp_err,
  output logic [CHIP_ADDR_WIDTH-1:0]           mem_addr,
  inout  wire  [DATA_WIDTH-1:0]                mem_data,
  output logic [NUM_CHIPS-1:0]                 mem_cs,
  output logic                                 mem_we,
  output logic                                 mem_oe
);

  localparam int ADDR_WIDTH = CHIP_ADDR_WIDTH + SEL_WIDTH;

  // Chip count widened by one bit so an index equal to 2^SEL_WIDTH-1 and a
  // full bank (NUM_CHIPS == 2^SEL_WIDTH) both compare correctly.
  localparam logic [SEL_WIDTH:0] NUM_CHIPS_L = NUM_CHIPS[SEL_WIDTH:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                       state_r;
  state_t                       state_s;

  logic                         req_ready_r;
  logic                         req_ready_s;
  logic                         rsp_valid_r;
  logic                         rsp_valid_s;
  logic                         rsp_err_r;
  logic                         rsp_err_s;
  logic [DATA_WIDTH-1:0]        rsp_rdata_r;
  logic [DATA_WIDTH-1:0]        rsp_rdata_s;
  logic [CHIP_ADDR_WIDTH-1:0]   mem_addr_r;
  logic [CHIP_ADDR_WIDTH-1:0]   mem_addr_s;
  logic [NUM_CHIPS-1:0]         mem_cs_r;
  logic [NUM_CHIPS-1:0]         mem_cs_s;
  logic                         mem_we_r;
  logic                         mem_we_s;
  logic                         mem_oe_r;
  logic                         mem_oe_s;
  logic                         drive_r;
  logic                         drive_s;
  logic [DATA_WIDTH-1:0]        wdata_r;
  logic [DATA_WIDTH-1:0]        wdata_s;

  logic [SEL_WIDTH-1:0]         req_idx_s;
  logic [CHIP_ADDR_WIDTH-1:0]   req_caddr_s;
  logic                         req_idx_ok_s;

  // One-hot chip select for a decoded chip index.
  function automatic logic [NUM_CHIPS-1:0] chip_select(input logic [SEL_WIDTH-1:0] idx);
    logic [NUM_CHIPS-1:0] sel;
    sel = '0;
    for (int i = 0; i < NUM_CHIPS; i++) begin
      if (idx == i[SEL_WIDTH-1:0]) begin
        sel[i] = 1'b1;
      end else begin
        sel[i] = 1'b0;
      end
    end
    return sel;
  endfunction

  assign req_idx_s    = req_addr[ADDR_WIDTH-1 -: SEL_WIDTH];
  assign req_caddr_s  = req_addr[CHIP_ADDR_WIDTH-1:0];
  assign req_idx_ok_s = ({1'b0, req_idx_s} < NUM_CHIPS_L);

  // The data bus is released except while a write access is on the bus.
  assign mem_data = drive_r ? wdata_r : {DATA_WIDTH{1'bz}};

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_rdata = rsp_rdata_r;
  assign mem_addr  = mem_addr_r;
  assign mem_cs    = mem_cs_r;
  assign mem_we    = mem_we_r;
  assign mem_oe    = mem_oe_r;

  // Next state and next values of every registered output.
  always_comb begin
    state_s     = state_r;
    rsp_err_s   = 1'b0;
    rsp_rdata_s = rsp_rdata_r;
    mem_addr_s  = mem_addr_r;
    mem_cs_s    = '0;
    mem_we_s    = 1'b0;
    mem_oe_s    = 1'b0;
    drive_s     = 1'b0;
    wdata_s     = wdata_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          wdata_s = req_wdata;
          if (!req_idx_ok_s) begin
            // Nonexistent chip: answer with an error, touch no chip.
            state_s   = RESP;
            rsp_err_s = 1'b1;
            if (req_we) begin
              rsp_rdata_s = rsp_rdata_r;
            end else begin
              rsp_rdata_s = '0;
            end
          end else if (req_we) begin
            state_s    = WRITE;
            mem_addr_s = req_caddr_s;
            mem_cs_s   = chip_select(req_idx_s);
            mem_we_s   = 1'b1;
            drive_s    = 1'b1;
          end else begin
            state_s    = READ;
            mem_addr_s = req_caddr_s;
            mem_cs_s   = chip_select(req_idx_s);
            mem_oe_s   = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WRITE: begin
        state_s = RESP;
      end
      READ: begin
        // The chip latched the word on the mid-cycle negedge and is
        // driving it now; capture it on the edge that ends READ.
        state_s     = RESP;
        rsp_rdata_s = mem_data;
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    req_ready_s = (state_s == IDLE);
    rsp_valid_s = (state_s == RESP);
  end

  // State register and output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= '0;
      mem_addr_r  <= '0;
      mem_cs_r    <= '0;
      mem_we_r    <= 1'b0;
      mem_oe_r    <= 1'b0;
      drive_r     <= 1'b0;
      wdata_r     <= '0;
    end else begin
      state_r     <= state_s;
      req_ready_r <= req_ready_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_err_r   <= rsp_err_s;
      rsp_rdata_r <= rsp_rdata_s;
      mem_addr_r  <= mem_addr_s;
      mem_cs_r    <= mem_cs_s;
      mem_we_r    <= mem_we_s;
      mem_oe_r    <= mem_oe_s;
      drive_r     <= drive_s;
      wdata_r     <= wdata_s;
    end
  end

  mem_ctrl_checker #(
    .NUM_CHIPS (NUM_CHIPS)
  ) u_checker (
    .clk       (clk),
    .rst       (rst),
    .mem_cs    (mem_cs_r),
    .mem_we    (mem_we_r),
    .mem_oe    (mem_oe_r),
    .drive     (drive_r),
    .rsp_valid (rsp_valid_r),
    .req_ready (req_ready_r)
  );

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: three SRAM chip models on the shared bus, a
// transaction-level reference model (memory array + expected response
// schedule) checked every cycle, plus pinned literal expectations.

module tb_mem_ctrl;

  localparam int CAW = 12;
  localparam int DW  = 8;
  localparam int NC  = 3;
  localparam int SW  = 2;
  localparam int AW  = CAW + SW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [CAW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;
  logic [NC-1:0] mem_cs;
  logic          mem_we;
  logic          mem_oe;

  mem_ctrl #(
    .CHIP_ADDR_WIDTH (CAW),
    .DATA_WIDTH      (DW),
    .NUM_CHIPS       (NC),
    .SEL_WIDTH       (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_oe    (mem_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- SRAM chip models ----------------
  logic [DW-1:0] chip_mem [NC][1<<CAW];
  logic [DW-1:0] chip_q   [NC];
  logic [DW-1:0] chip_drv;
  logic          chip_en;

  always @(posedge clk) begin
    for (int i = 0; i < NC; i++)
      if (mem_cs[i] && mem_we) chip_mem[i][mem_addr] <= mem_data;
  end

  always @(negedge clk) begin
    for (int i = 0; i < NC; i++)
      if (mem_cs[i] && !mem_we) chip_q[i] <= chip_mem[i][mem_addr];
  end

  always_comb begin
    chip_en  = 1'b0;
    chip_drv = '0;
    for (int i = 0; i < NC; i++)
      if (mem_cs[i] && mem_oe && !mem_we) begin
        chip_en  = 1'b1;
        chip_drv = chip_q[i];
      end
  end

  assign mem_data = chip_en ? chip_drv : {DW{1'bz}};

  // ---------------- literal expectations ----------------
  localparam int K_CS = 0, K_WE = 1, K_OE = 2, K_ADDR = 3, K_DATA = 4;
  localparam int K_RVALID = 5, K_RDATA = 6, K_ERR = 7, K_READY = 8;
  string knames [9] = '{"cs", "we", "oe", "addr", "data", "rvalid", "rdata", "err", "ready"};

  typedef struct {
    int          at;
    int          kind;
    logic [31:0] val;
  } lit_t;
  lit_t lit_q[$];

  task automatic add_lit(input int at, input int kind, input logic [31:0] val);
    lit_t e;
    e.at = at; e.kind = kind; e.val = val;
    lit_q.push_back(e);
  endtask

  // ---------------- reference model + compare ----------------
  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_mem [int];
  bit            started = 1'b0;
  int            free_cyc = 0;
  int            acc_cyc = -1;
  logic [NC-1:0] acc_cs;
  logic          acc_we;
  logic [CAW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;
  int            rsp_cyc = -1;
  logic          rsp_err_e;
  logic          rsp_rd;
  logic [DW-1:0] rsp_data;
  logic [DW-1:0] exp_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    bit            acc;
    int            idx;
    logic [31:0]   act;
    if (started) begin
      if (cyc == rsp_cyc && rsp_rd) exp_rdata = rsp_data;
      acc = (cyc == acc_cyc);
      chk("req_ready", 32'(req_ready), 32'(cyc >= free_cyc));
      chk("rsp_valid", 32'(rsp_valid), 32'(cyc == rsp_cyc));
      if (cyc == rsp_cyc) chk("rsp_err", 32'(rsp_err), 32'(rsp_err_e));
      chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
      chk("mem_cs", 32'(mem_cs), acc ? 32'(acc_cs) : 32'd0);
      chk("mem_we", 32'(mem_we), 32'(acc && acc_we));
      chk("mem_oe", 32'(mem_oe), 32'(acc && !acc_we));
      if (acc) chk("mem_addr", 32'(mem_addr), 32'(acc_addr));
      if (acc && acc_we) chk("mem_data", 32'(mem_data), 32'(acc_wdata));
      chk("we_oe_excl", 32'(mem_we && mem_oe), 32'd0);
      chk("cs_onehot0", 32'($onehot0(mem_cs)), 32'd1);
      foreach (lit_q[i]) begin
        if (lit_q[i].at == cyc) begin
          case (lit_q[i].kind)
            K_CS:     act = 32'(mem_cs);
            K_WE:     act = 32'(mem_we);
            K_OE:     act = 32'(mem_oe);
            K_ADDR:   act = 32'(mem_addr);
            K_DATA:   act = 32'(mem_data);
            K_RVALID: act = 32'(rsp_valid);
            K_RDATA:  act = 32'(rsp_rdata);
            K_ERR:    act = 32'(rsp_err);
            default:  act = 32'(req_ready);
          endcase
          chk($sformatf("lit_%s", knames[lit_q[i].kind]), act, lit_q[i].val);
        end
      end
    end
    if (rst) begin
      started   = 1'b1;
      rsp_cyc   = -1;
      acc_cyc   = -1;
      free_cyc  = cyc + 1;
      exp_rdata = '0;
    end else if (started && req_valid && cyc >= free_cyc) begin
      idx = int'(req_addr[AW-1 -: SW]);
      rsp_rd = !req_we;
      if (idx >= NC) begin
        rsp_cyc   = cyc + 1;
        rsp_err_e = 1'b1;
        rsp_data  = '0;
        free_cyc  = cyc + 2;
      end else begin
        acc_cyc   = cyc + 1;
        acc_cs    = NC'(1 << idx);
        acc_we    = req_we;
        acc_addr  = req_addr[CAW-1:0];
        acc_wdata = req_wdata;
        rsp_cyc   = cyc + 2;
        rsp_err_e = 1'b0;
        free_cyc  = cyc + 3;
        if (req_we) begin
          model_mem[int'(req_addr)] = req_wdata;
          rsp_data = '0;
        end else begin
          rsp_data = model_mem.exists(int'(req_addr)) ? model_mem[int'(req_addr)] : '0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] d, input bit keep);
    int n;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = d;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      $display("FAIL issue_timeout cyc=%0d got=ready_low want=ready_high", cyc);
      add_lit(cyc + 1, K_READY, 32'd1);
    end
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;
  endtask

  logic [AW-1:0] wr_list[$];
  logic [AW-1:0] ra;
  logic [AW-1:0] bb_addr [4] = '{14'h0100, 14'h1200, 14'h2300, 14'h0FFF};
  logic [SW-1:0] ix;
  logic [CAW-1:0] ca;
  logic          w;
  logic [DW-1:0] d;
  bit            kp;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    add_lit(cyc, K_READY, 32'd1);
    add_lit(cyc, K_RDATA, 32'd0);
    add_lit(cyc, K_CS, 32'd0);
    @(posedge clk); #1;

    // Basic write then read of chip 0.
    issue(1'b1, 14'h0010, 8'h5A, 1'b0);
    add_lit(cyc, K_CS, 32'h1);
    add_lit(cyc, K_WE, 32'd1);
    add_lit(cyc, K_ADDR, 32'h010);
    add_lit(cyc, K_DATA, 32'h5A);
    add_lit(cyc + 1, K_RVALID, 32'd1);
    add_lit(cyc + 1, K_ERR, 32'd0);
    issue(1'b0, 14'h0010, 8'h00, 1'b0);
    add_lit(cyc, K_OE, 32'd1);
    add_lit(cyc + 1, K_RVALID, 32'd1);
    add_lit(cyc + 1, K_RDATA, 32'h5A);

    // Top-of-chip boundary addresses, no aliasing across chips.
    issue(1'b1, 14'h2FFF, 8'hC3, 1'b0);
    add_lit(cyc, K_CS, 32'h4);
    add_lit(cyc, K_ADDR, 32'hFFF);
    issue(1'b1, 14'h1FFF, 8'h11, 1'b0);
    add_lit(cyc, K_CS, 32'h2);
    add_lit(cyc, K_ADDR, 32'hFFF);
    issue(1'b1, 14'h2000, 8'h99, 1'b0);
    add_lit(cyc, K_ADDR, 32'h000);
    issue(1'b0, 14'h2FFF, 8'h00, 1'b0);
    add_lit(cyc + 1, K_RDATA, 32'hC3);
    issue(1'b0, 14'h1FFF, 8'h00, 1'b0);
    add_lit(cyc + 1, K_RDATA, 32'h11);

    // Nonexistent chip: errored write keeps rdata, errored read clears it.
    issue(1'b1, 14'h3ABC, 8'h44, 1'b0);
    add_lit(cyc, K_RVALID, 32'd1);
    add_lit(cyc, K_ERR, 32'd1);
    add_lit(cyc, K_CS, 32'd0);
    add_lit(cyc, K_RDATA, 32'h11);
    issue(1'b0, 14'h3000, 8'h00, 1'b0);
    add_lit(cyc, K_RVALID, 32'd1);
    add_lit(cyc, K_ERR, 32'd1);
    add_lit(cyc, K_RDATA, 32'h00);
    add_lit(cyc, K_CS, 32'd0);

    // Back-to-back with req_valid held high.
    for (int j = 0; j < 8; j++) begin
      issue(j[0] ? 1'b0 : 1'b1, bb_addr[j / 2], 8'(8'h30 + j / 2), j != 7);
      if (j[0]) add_lit(cyc + 1, K_RDATA, 32'(8'h30 + j / 2));
    end

    // Reset during a READ: no response, reset values next cycle.
    issue(1'b0, 14'h2FFF, 8'h00, 1'b0);
    @(posedge clk); #1;
    issue(1'b0, 14'h0010, 8'h00, 1'b0);
    rst = 1'b1;
    add_lit(cyc + 1, K_RVALID, 32'd0);
    add_lit(cyc + 1, K_READY, 32'd1);
    add_lit(cyc + 1, K_CS, 32'd0);
    add_lit(cyc + 1, K_OE, 32'd0);
    add_lit(cyc + 1, K_RDATA, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Reset during a WRITE: the chip still captures the data.
    issue(1'b1, 14'h0200, 8'hE7, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    issue(1'b0, 14'h0200, 8'h00, 1'b0);
    add_lit(cyc + 1, K_RDATA, 32'hE7);

    // Randomized traffic.
    for (int k = 0; k < 200; k++) begin
      d  = 8'($urandom);
      kp = ($urandom_range(0, 3) == 0);
      if (wr_list.size() > 0 && $urandom_range(0, 2) == 0) begin
        ra = wr_list[$urandom_range(0, wr_list.size() - 1)];
        w  = 1'b0;
      end else begin
        ix = SW'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0:       ca = 12'h000;
          1:       ca = 12'hFFF;
          default: ca = CAW'($urandom);
        endcase
        ra = {ix, ca};
        if (int'(ix) >= NC) begin
          w = 1'($urandom);
        end else begin
          w = 1'b1;
          wr_list.push_back(ra);
        end
      end
      issue(w, ra, d, kp);
      if (!kp) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end
    req_valid = 1'b0;

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
